uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver with runtime baud, parity enable and parity type. It is the downstream counterpart of the team's uart_tx and decodes its line format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Asynchronous rx line is synchronised, frames are decoded by mid-bit sampling, and each byte is presented with a one-cycle valid pulse plus error flags.
- Sits between the pad and the system-side consumer (FIFO or CSR block).

Parameters:
DATA_WIDTH, 8, data bits per frame; only 8 is supported, other values are unsupported.
SYNC_STAGES, 2, synchroniser flops on rx; legal range 2..3.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
data  output  8  last received byte, held until the next valid
valid  output  1  one-cycle pulse: data/parity_error/frame_error updated
parity_error  output  1  parity mismatch on the byte flagged by valid (0 when parity disabled)
frame_error  output  1  stop bit sampled low on the byte flagged by valid
busy  output  1  high from start-edge detection until return to IDLE
baud_divider  input  12  bit period = baud_divider+1 clk cycles; must be >= 3
parity_en  input  1  expect a parity bit
parity_type_odd  input  1  1 = odd parity, 0 = even parity

Behaviour:
- Reset (async, active-high): state IDLE; all synchroniser flops = 1; counters = 0; data=0, valid=0, parity_error=0, frame_error=0, busy=0.
- rx passes through SYNC_STAGES flops (reset value 1). rx_s is the synchronised line. The falling edge is rx_s==0 while previous rx_s==1.
- Config registering: baud_divider, parity_en and parity_type_odd are captured in the cycle the falling edge is detected in IDLE. They are constant for the rest of the frame; mid-frame input changes are ignored.
- Counter: baud_counter runs 0..div_r, then wraps to 0. It is held at 0 in IDLE.
- State IDLE: on falling edge, go to START_BIT; busy=1 from the next cycle; counter starts at 0.
- State START_BIT: at counter == div_r>>1 (floor), sample rx_s.
  - If 1 (glitch): go to IDLE, no valid.
  - If 0: reset counter to 0 and go to DATA_BITS. All later samples land at mid-bit.
- State DATA_BITS: at counter == div_r, shift rx_s into shift_reg[bit_idx] (LSB first), XOR it into a running parity, and increment bit_idx. After bit_idx 7 is sampled, go to PARITY_BIT if par_en_r, else STOP_BIT.
- State PARITY_BIT: at counter == div_r, sample p. Parity error is set when p != (running_xor ^ par_odd_r).
- State STOP_BIT: at counter == div_r, sample the stop bit. In the next cycle:
  - valid=1 for exactly one cycle;
  - data=shift_reg;
  - frame_error = ~stop_sample;
  - parity_error = (mismatch & par_en_r).
  - State returns to IDLE in that same cycle and busy drops to 0.
- Back-to-back frames: because return to IDLE happens at mid-stop-bit, the next start edge must be detected. A start edge that arrives within half a bit of the stop sample is accepted.
- Frame error with line held low (break): after the frame_error valid, IDLE is entered with rx_s==0. No new frame starts until a 1→0 edge is seen.
- Latency: valid asserts SYNC_STAGES+1 cycles after the synchronised mid-stop sample point, measured relative to the rx pin.
- Reset mid-frame: immediate abort, no valid, outputs return to reset values.
- baud_divider < 3: behaviour undefined. The bench does not test it.

Decomposition:
- Package uart_pkg holds:
  - uart_state_t enum (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT), shared with uart_tx;
  - UART_DATA_WIDTH constant;
  - function uart_parity(data, odd) returning the expected parity bit.
- One sub-module, sync_nff (parameter STAGES, reset value 1), used for the rx synchroniser.

Test Plan:
- baud_divider=4, parity off, send 0xA5 (frame 0,1,0,1,0,0,1,0,1,1) -> one valid pulse, data=0xA5, parity_error=0, frame_error=0; busy high throughout the frame.
- baud_divider=9, parity_en=1 even, send 0x3C with parity bit 0 -> data=0x3C, errors 0. Repeat with parity bit 1 -> parity_error=1, data=0x3C.
- baud_divider=9, rx low for 3 cycles then high -> no valid, busy returns to 0, state IDLE.
- baud_divider=4, send 0x81 with stop bit forced 0 -> valid, data=0x81, frame_error=1. Then line held low -> no further valid until a high then falling edge.
- Loopback uart_tx.tx→rx, baud_divider=433, parity odd, bytes 0x00, 0xFF, 0x55 back-to-back -> three valids in order, all errors 0.
- rst asserted during DATA_BITS of 0xC3, released, then 0x12 sent -> only one valid, data=0x12.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: line-format definitions shared by uart_tx and uart_rx
package uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} uart_state_t;
  function automatic logic uart_parity(input logic [UART_DATA_WIDTH-1:0] data, input logic odd);
    return ^data ^ odd;
  endfunction
endpackage

// File: rtl/sync_nff.sv
// sync_nff: multi-flop synchroniser for a single asynchronous bit
module sync_nff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= {STAGES{RESET_VAL}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver, 8N1 with optional even/odd parity
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy,
  input  logic [11:0]           baud_divider,
  input  logic                  parity_en,
  input  logic                  parity_type_odd
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  uart_state_t state;
  logic rx_s, rx_prev, fall, tick;
  logic [11:0] div_r, cnt;
  logic par_en_r, par_odd_r, par_acc, mismatch;
  logic [IW-1:0] bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  sync_nff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign fall = rx_prev & ~rx_s;
  assign tick = cnt == div_r;
  // config is latched on the start edge so the whole frame uses one bit timing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      rx_prev      <= 1'b1;
      cnt          <= '0;
      div_r        <= '0;
      par_en_r     <= 1'b0;
      par_odd_r    <= 1'b0;
      par_acc      <= 1'b0;
      mismatch     <= 1'b0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      data         <= '0;
      valid        <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      valid   <= 1'b0;
      cnt     <= (state == IDLE || tick) ? '0 : cnt + 12'd1;
      case (state)
        IDLE: if (fall) begin
          state     <= START_BIT;
          busy      <= 1'b1;
          div_r     <= baud_divider;
          par_en_r  <= parity_en;
          par_odd_r <= parity_type_odd;
        end
        START_BIT: if (cnt == (div_r >> 1)) begin
          cnt      <= '0;
          par_acc  <= 1'b0;
          mismatch <= 1'b0;
          bit_idx  <= '0;
          state    <= rx_s ? IDLE : DATA_BITS;
          busy     <= ~rx_s;
        end
        DATA_BITS: if (tick) begin
          shift_reg[bit_idx] <= rx_s;
          par_acc            <= par_acc ^ rx_s;
          bit_idx            <= bit_idx + 1'b1;
          if (bit_idx == LAST) state <= par_en_r ? PARITY_BIT : STOP_BIT;
        end
        PARITY_BIT: if (tick) begin
          mismatch <= rx_s != (par_acc ^ par_odd_r);
          state    <= STOP_BIT;
        end
        STOP_BIT: if (tick) begin
          valid        <= 1'b1;
          data         <= shift_reg;
          frame_error  <= ~rx_s;
          parity_error <= mismatch & par_en_r;
          state        <= IDLE;
          busy         <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus scored against a frame-level reference model
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [11:0] baud_divider = 12'd4;
  logic parity_en = 1'b0, parity_type_odd = 1'b0;
  logic [7:0] data;
  logic valid, parity_error, frame_error, busy;
  int checks = 0, errors = 0, dbl = 0;
  logic [9:0] got[$], exp_q[$];
  logic prev_valid = 1'b0;
  logic busy_all = 1'b1;

  uart_rx dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .parity_error(parity_error), .frame_error(frame_error), .busy(busy),
    .baud_divider(baud_divider), .parity_en(parity_en), .parity_type_odd(parity_type_odd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) got.push_back({data, parity_error, frame_error});
    if (valid && prev_valid) dbl++;
    prev_valid = valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, want);
    end
  endtask

  // parity bit that makes the total count of ones even (or odd)
  function automatic logic good_pbit(input logic [7:0] b, input logic odd);
    return (($countones(b) % 2) == 1) != odd;
  endfunction

  task automatic bit_out(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [11:0] div, input logic pen,
                      input logic podd, input logic pbit, input logic stop, input logic scramble);
    int bp;
    bp = int'(div) + 1;
    baud_divider = div;
    parity_en = pen;
    parity_type_odd = podd;
    bit_out(1'b0, bp);
    if (scramble) begin
      baud_divider = 12'($urandom_range(3, 4095));
      parity_en = 1'($urandom);
      parity_type_odd = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      bit_out(b[i], bp);
      busy_all &= busy;
    end
    if (pen) bit_out(pbit, bp);
    bit_out(stop, bp);
    exp_q.push_back({b, pen && (pbit != good_pbit(b, podd)), !stop});
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_count"}, got.size(), exp_q.size());
    while (exp_q.size() > 0 && got.size() > 0) chk(tag, 32'(got.pop_front()), 32'(exp_q.pop_front()));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    bit_out(1'b1, 5);
    busy_all = 1'b1;
    send(8'hA5, 12'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("busy_frame", busy_all, 1);
    drain("a5", 200);
    bit_out(1'b1, 20);
    send(8'h3C, 12'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("3c_ok", 200);
    bit_out(1'b1, 20);
    send(8'h3C, 12'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("3c_perr", 200);
    baud_divider = 12'd9;
    bit_out(1'b0, 3);
    bit_out(1'b1, 40);
    drain("glitch", 50);
    chk("glitch_busy", busy, 0);
    send(8'h81, 12'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("break", 200);
    bit_out(1'b0, 60);
    drain("break_hold", 10);
    bit_out(1'b1, 10);
    send(8'h5A, 12'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("after_break", 200);
    bit_out(1'b1, 30);
    send(8'h00, 12'd433, 1'b1, 1'b1, good_pbit(8'h00, 1'b1), 1'b1, 1'b0);
    send(8'hFF, 12'd433, 1'b1, 1'b1, good_pbit(8'hFF, 1'b1), 1'b1, 1'b0);
    send(8'h55, 12'd433, 1'b1, 1'b1, good_pbit(8'h55, 1'b1), 1'b1, 1'b0);
    drain("b2b", 3000);
    bit_out(1'b1, 10);
    baud_divider = 12'd4;
    parity_en = 1'b0;
    bit_out(1'b0, 5);
    bit_out(1'b1, 5);
    bit_out(1'b1, 5);
    bit_out(1'b0, 5);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data, 0);
    chk("midrst_valid", valid, 0);
    rst = 1'b0;
    bit_out(1'b1, 20);
    send(8'h12, 12'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("after_rst", 200);
    repeat (24) begin
      logic [11:0] div;
      logic [7:0] b;
      logic pen, podd, pbit, stop;
      div = 12'($urandom_range(3, 24));
      b = 8'($urandom);
      pen = 1'($urandom);
      podd = 1'($urandom);
      pbit = good_pbit(b, podd) ^ ($urandom_range(0, 3) == 0);
      stop = $urandom_range(0, 6) != 0;
      bit_out(1'b1, 2 * (int'(div) + 1));
      send(b, div, pen, podd, pbit, stop, 1'b1);
    end
    drain("rand", 500);
    chk("single_cycle_valid", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
